// File: rtl/seq_match_logger.sv
// ============================================================================
// Module   : seq_match_logger
// Brief    : Timestamps 10011-detector matches into a show-ahead FIFO, with a
//            saturating match counter and a sticky overflow flag.
// Revision : 1.0
// ============================================================================
`default_nettype none

module seq_match_logger #(
  parameter int TS_W  = 16,
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     clr,
  input  logic                     match_in,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [TS_W-1:0]          rd_data,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [CNT_W-1:0]         match_count,
  output logic [TS_W-1:0]          tstamp,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]     C_PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [TS_W-1:0] C_TS_ONE  = {{(TS_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [TS_W-1:0]  r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic [TS_W-1:0]  r_tstamp;
  logic [CNT_W-1:0] r_count;
  logic             r_overflow;

  logic w_empty;
  logic w_full;
  logic w_event;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_wptr == r_rptr);
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_event = en && match_in;
  assign w_pop   = rd_en && !w_empty;
  // A pop frees the head slot, so a full FIFO can still accept a same-cycle push.
  assign w_push  = w_event && (!w_full || w_pop);
  assign w_drop  = w_event && w_full && !w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_tstamp   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_tstamp   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (en)
        r_tstamp <= r_tstamp + C_TS_ONE;
      if (w_push)
        r_wptr <= r_wptr + C_PTR_ONE;
      if (w_pop)
        r_rptr <= r_rptr + C_PTR_ONE;
      if (w_event && (r_count != '1))
        r_count <= r_count + C_CNT_ONE;
      if (w_drop)
        r_overflow <= 1'b1;
    end
  end

  // Storage is reset so rd_data comes out of reset as zero.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
    end else if (!clr && w_push) begin
      r_mem[r_wptr[AW-1:0]] <= r_tstamp;
    end
  end

  assign rd_valid    = !w_empty;
  assign rd_data     = r_mem[r_rptr[AW-1:0]];
  assign fifo_level  = r_wptr - r_rptr;
  assign match_count = r_count;
  assign tstamp      = r_tstamp;
  assign overflow    = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_seq_match_logger.sv
// ============================================================================
// Module   : tb_seq_match_logger
// Brief    : Scoreboard bench for seq_match_logger (default and narrow builds).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_seq_match_logger;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0, clr = 1'b0, match_in = 1'b0, rd_en = 1'b0;
  logic        rd_valid, overflow;
  logic [15:0] rd_data, match_count, tstamp;
  logic [3:0]  fifo_level;

  logic        s_en = 1'b0, s_clr = 1'b0, s_match = 1'b0, s_rd = 1'b0;
  logic        s_valid, s_overflow;
  logic [3:0]  s_data, s_tstamp, s_level;
  logic [2:0]  s_count;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int s_q[$];

  always #5 clk = ~clk;

  seq_match_logger #(.TS_W(16), .DEPTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .match_in(match_in), .rd_en(rd_en),
    .rd_valid(rd_valid), .rd_data(rd_data), .fifo_level(fifo_level),
    .match_count(match_count), .tstamp(tstamp), .overflow(overflow)
  );

  seq_match_logger #(.TS_W(4), .DEPTH(8), .CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .en(s_en), .clr(s_clr), .match_in(s_match), .rd_en(s_rd),
    .rd_valid(s_valid), .rd_data(s_data), .fifo_level(s_level),
    .match_count(s_count), .tstamp(s_tstamp), .overflow(s_overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitors: every accepted pop is checked against the head of the expected queue.
  always @(negedge clk) begin
    if (!reset && rd_valid && rd_en && !clr) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL pop_unexpected: got %0d, expected no entry", rd_data);
      end else begin
        chk("rd_data", int'(rd_data), exp_q.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && s_valid && s_rd) begin
      if (s_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL small_pop_unexpected: got %0d, expected no entry", s_data);
      end else begin
        chk("small_rd_data", int'(s_data), s_q.pop_front());
      end
    end
  end

  task automatic cyc(input logic e, input logic m, input logic r, input logic c);
    en = e; match_in = m; rd_en = r; clr = c;
    if (c) exp_q.delete();
    @(posedge clk); #1;
    en = 1'b0; match_in = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  task automatic scyc(input logic e, input logic m, input logic r);
    s_en = e; s_match = m; s_rd = r;
    @(posedge clk); #1;
    s_en = 1'b0; s_match = 1'b0; s_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [9:0] stream;
    logic [3:0] hist;
    logic       b;

    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk("reset_tstamp", int'(tstamp), 0);
    chk("reset_rd_valid", int'(rd_valid), 0);
    chk("reset_level", int'(fifo_level), 0);
    chk("reset_count", int'(match_count), 0);
    chk("reset_overflow", int'(overflow), 0);
    chk("reset_rd_data", int'(rd_data), 0);

    // T1: events at tstamp 3 and 7
    exp_q.push_back(3); exp_q.push_back(7);
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, (i == 3) || (i == 7), 1'b0, 1'b0);
      if (i == 2) chk("t1_valid_before", int'(rd_valid), 0);
      if (i == 3) chk("t1_valid_after", int'(rd_valid), 1);
    end
    chk("t1_level", int'(fifo_level), 2);
    chk("t1_count", int'(match_count), 2);
    chk("t1_tstamp", int'(tstamp), 10);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_drained_valid", int'(rd_valid), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_empty_pop_level", int'(fifo_level), 0);

    // T2: detector-aligned stream 1001110011
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_clr_tstamp", int'(tstamp), 0);
    exp_q.push_back(4); exp_q.push_back(9);
    stream = 10'b1001110011;
    hist = 4'b0;
    for (int i = 0; i < 10; i++) begin
      b = stream[9-i];
      cyc(1'b1, ({hist, b} == 5'b10011), 1'b0, 1'b0);
      hist = {hist[2:0], b};
    end
    chk("t2_level", int'(fifo_level), 2);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t2_valid", int'(rd_valid), 0);
    chk("t2_level_empty", int'(fifo_level), 0);

    // T3: 10 events into an 8-deep FIFO
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t3_level", int'(fifo_level), 8);
    chk("t3_overflow", int'(overflow), 1);
    chk("t3_count", int'(match_count), 10);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3_drained_valid", int'(rd_valid), 0);
    chk("t3_overflow_sticky", int'(overflow), 1);

    // T6: clr beats a same-cycle event and pop with 3 stored
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t6_level_pre", int'(fifo_level), 3);
    cyc(1'b1, 1'b1, 1'b1, 1'b1);
    chk("t6_level", int'(fifo_level), 0);
    chk("t6_count", int'(match_count), 0);
    chk("t6_tstamp", int'(tstamp), 0);
    chk("t6_overflow", int'(overflow), 0);
    chk("t6_valid", int'(rd_valid), 0);

    // T4: full FIFO, push and pop together
    for (int i = 0; i < 8; i++) exp_q.push_back(i);
    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("t4_level_full", int'(fifo_level), 8);
    exp_q.push_back(8);
    cyc(1'b1, 1'b1, 1'b1, 1'b0);
    chk("t4_level", int'(fifo_level), 8);
    chk("t4_overflow", int'(overflow), 0);
    chk("t4_count", int'(match_count), 9);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("t4_drained_level", int'(fifo_level), 0);

    // T5: narrow build, tstamp wrap and count saturation
    for (int i = 0; i < 15; i++) scyc(1'b1, 1'b0, 1'b0);
    chk("t5_tstamp_pre", int'(s_tstamp), 15);
    s_q.push_back(15);
    for (int i = 0; i < 7; i++) s_q.push_back(i);
    for (int i = 0; i < 9; i++) scyc(1'b1, 1'b1, 1'b0);
    chk("t5_count_sat", int'(s_count), 7);
    chk("t5_level", int'(s_level), 8);
    chk("t5_overflow", int'(s_overflow), 1);
    chk("t5_tstamp_wrap", int'(s_tstamp), 8);
    for (int i = 0; i < 8; i++) scyc(1'b0, 1'b0, 1'b1);
    chk("t5_drained_valid", int'(s_valid), 0);

    // Asynchronous reset mid-operation
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    chk("async_level_pre", int'(fifo_level), 2);
    #2 reset = 1'b1;
    exp_q.delete();
    #1;
    chk("async_level", int'(fifo_level), 0);
    chk("async_valid", int'(rd_valid), 0);
    chk("async_tstamp", int'(tstamp), 0);
    chk("async_count", int'(match_count), 0);
    @(posedge clk); #1 reset = 1'b0;

    chk("queue_empty", exp_q.size(), 0);
    chk("small_queue_empty", s_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
